// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the pipeline hazard controller
package cpu_pkg;

    localparam logic [1:0] FWD_ID_EX = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over increment; en low freezes the counter completely.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (clr) begin
                count_d = '0;
            end else if (inc && (count_q != '1)) begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall and redirect flush control for the 5-stage core
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs_addr,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic                  redirect,
    input  logic                  perf_clr,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stalled,
    output logic [PERF_W-1:0]     stall_cnt,
    output logic [PERF_W-1:0]     flush_cnt
);

    localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

    // The nearer producer (EXE/MEM) holds the younger value, so it is checked first.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_addr,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_addr
    );
        if (m_we && (m_addr != '0) && (m_addr == src)) begin
            return FWD_MEM;
        end else if (w_we && (w_addr != '0) && (w_addr == src)) begin
            return FWD_WB;
        end
        return FWD_ID_EX;
    endfunction

    hz_state_e  state_q;
    hz_state_e  state_d;
    logic [3:0] rem_q;
    logic [3:0] rem_d;

    logic load_use;
    logic rs_hit;
    logic rt_hit;
    logic stall_req;

    assign rs_hit   = id_uses_rs && (id_rs_addr == ex_waddr);
    assign rt_hit   = id_uses_rt && (id_rt_addr == ex_waddr);
    assign load_use = id_valid && ex_mem_read && ex_reg_write &&
                      (ex_waddr != '0) && (rs_hit || rt_hit);

    // In STALL the ID/EXE inputs describe the inserted bubble, so the stall is held by state alone.
    assign stall_req = (state_q == ST_STALL) || load_use;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (enable) begin
            if (redirect) begin
                state_d = ST_RUN;
                rem_d   = '0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (load_use && (LOAD_LAT > 1)) begin
                            state_d = ST_STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                    ST_STALL: begin
                        if (rem_q <= 4'd1) begin
                            state_d = ST_RUN;
                            rem_d   = '0;
                        end else begin
                            rem_d = rem_q - 4'd1;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stalled      = 1'b0;
        fwd_a_sel    = FWD_ID_EX;
        fwd_b_sel    = FWD_ID_EX;
        if (arst_n) begin
            fwd_a_sel = fwd_sel(ex_rs_addr, mem_reg_write, mem_waddr, wb_reg_write, wb_waddr);
            fwd_b_sel = fwd_sel(ex_rt_addr, mem_reg_write, mem_waddr, wb_reg_write, wb_waddr);
            if (enable) begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                if (redirect) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (stall_req) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stalled     = 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (enable),
        .clr    (perf_clr),
        .inc    (stalled),
        .count  (stall_cnt)
    );

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (enable),
        .clr    (perf_clr),
        .inc    (redirect),
        .count  (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with LOAD_LAT=1 and LOAD_LAT=3 instances
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       enable;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] ex_rs_addr;
    logic [4:0] ex_rt_addr;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] ex_waddr;
    logic       mem_reg_write;
    logic [4:0] mem_waddr;
    logic       wb_reg_write;
    logic [4:0] wb_waddr;
    logic       redirect;
    logic       perf_clr;

    logic       pc_en1, if_id_en1, if_id_flush1, id_ex_flush1, ex_mem_flush1, stalled1;
    logic [1:0] fwd_a1, fwd_b1;
    logic [3:0] stall_cnt1, flush_cnt1;
    logic       pc_en3, if_id_en3, if_id_flush3, id_ex_flush3, ex_mem_flush3, stalled3;
    logic [1:0] fwd_a3, fwd_b3;
    logic [3:0] stall_cnt3, flush_cnt3;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .PERF_W(4)) u_dut1 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr),
        .mem_reg_write(mem_reg_write), .mem_waddr(mem_waddr),
        .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr),
        .redirect(redirect), .perf_clr(perf_clr),
        .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1),
        .id_ex_flush(id_ex_flush1), .ex_mem_flush(ex_mem_flush1),
        .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1), .stalled(stalled1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .PERF_W(4)) u_dut3 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr),
        .mem_reg_write(mem_reg_write), .mem_waddr(mem_waddr),
        .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr),
        .redirect(redirect), .perf_clr(perf_clr),
        .pc_en(pc_en3), .if_id_en(if_id_en3), .if_id_flush(if_id_flush3),
        .id_ex_flush(id_ex_flush3), .ex_mem_flush(ex_mem_flush3),
        .fwd_a_sel(fwd_a3), .fwd_b_sel(fwd_b3), .stalled(stalled3),
        .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    // Control vector: {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, stalled, fwd_a, fwd_b}
    localparam logic [9:0] C_OFF   = 10'b00_000_0_00_00;
    localparam logic [9:0] C_IDLE  = 10'b11_000_0_00_00;
    localparam logic [9:0] C_STALL = 10'b00_010_1_00_00;
    localparam logic [9:0] C_FLUSH = 10'b11_111_0_00_00;

    typedef struct {
        string      name;
        logic [9:0] c1;
        logic [9:0] c3;
        logic [3:0] s1;
        logic [3:0] f1;
        logic [3:0] s3;
        logic [3:0] f3;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    wire [9:0] act1 = {pc_en1, if_id_en1, if_id_flush1, id_ex_flush1, ex_mem_flush1, stalled1, fwd_a1, fwd_b1};
    wire [9:0] act3 = {pc_en3, if_id_en3, if_id_flush3, id_ex_flush3, ex_mem_flush3, stalled3, fwd_a3, fwd_b3};

    function automatic logic [9:0] with_fwd(input logic [9:0] base, input logic [1:0] fa, input logic [1:0] fb);
        return base | {6'b0, fa, fb};
    endfunction

    task automatic chk(input string nm, input string what, input logic [9:0] act, input logic [9:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s %s: got %b required %b", nm, what, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "dut1_ctl",   act1, e.c1);
            chk(e.name, "dut1_stall", {6'b0, stall_cnt1}, {6'b0, e.s1});
            chk(e.name, "dut1_flush", {6'b0, flush_cnt1}, {6'b0, e.f1});
            chk(e.name, "dut3_ctl",   act3, e.c3);
            chk(e.name, "dut3_stall", {6'b0, stall_cnt3}, {6'b0, e.s3});
            chk(e.name, "dut3_flush", {6'b0, flush_cnt3}, {6'b0, e.f3});
        end
    end

    task automatic step(input string nm, input logic [9:0] c1, input logic [9:0] c3,
                        input logic [3:0] s1, input logic [3:0] f1,
                        input logic [3:0] s3, input logic [3:0] f3);
        exp_t e;
        e.name = nm; e.c1 = c1; e.c3 = c3;
        e.s1 = s1; e.f1 = f1; e.s3 = s3; e.f3 = f3;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        arst_n = 1'b1; enable = 1'b1; id_valid = 1'b0;
        id_rs_addr = '0; id_rt_addr = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs_addr = '0; ex_rt_addr = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_waddr = '0; mem_reg_write = 1'b0; mem_waddr = '0;
        wb_reg_write = 1'b0; wb_waddr = '0; redirect = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic hazard_rs();
        id_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        ex_waddr = 5'd8; id_rs_addr = 5'd8; id_uses_rs = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_in();
        arst_n = 1'b0;
        // A would-be MEM forward under reset must still read 00.
        ex_rs_addr = 5'd5; mem_waddr = 5'd5; mem_reg_write = 1'b1;
        @(posedge clk);
        #1;
        step("reset", C_OFF, C_OFF, 0, 0, 0, 0);

        clear_in();
        step("idle", C_IDLE, C_IDLE, 0, 0, 0, 0);

        ex_rs_addr = 5'd5; ex_rt_addr = 5'd7; mem_waddr = 5'd5; wb_waddr = 5'd5;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        step("fwd_mem_prio", with_fwd(C_IDLE, 2'b10, 2'b00), with_fwd(C_IDLE, 2'b10, 2'b00), 0, 0, 0, 0);
        mem_reg_write = 1'b0;
        step("fwd_wb", with_fwd(C_IDLE, 2'b01, 2'b00), with_fwd(C_IDLE, 2'b01, 2'b00), 0, 0, 0, 0);
        mem_reg_write = 1'b1; ex_rt_addr = 5'd6; mem_waddr = 5'd6;
        step("fwd_split", with_fwd(C_IDLE, 2'b01, 2'b10), with_fwd(C_IDLE, 2'b01, 2'b10), 0, 0, 0, 0);
        ex_rs_addr = '0; ex_rt_addr = '0; mem_waddr = '0; wb_waddr = '0;
        step("fwd_r0", C_IDLE, C_IDLE, 0, 0, 0, 0);

        clear_in();
        hazard_rs();
        step("lu_cyc1", C_STALL, C_STALL, 0, 0, 0, 0);
        clear_in();
        step("lu_cyc2", C_IDLE, C_STALL, 1, 0, 1, 0);
        step("lu_cyc3", C_IDLE, C_STALL, 1, 0, 2, 0);
        step("lu_done", C_IDLE, C_IDLE, 1, 0, 3, 0);

        ex_mem_read = 1'b1; ex_reg_write = 1'b1; id_valid = 1'b1; id_uses_rs = 1'b1;
        perf_clr = 1'b1;
        step("lu_r0_clr", C_IDLE, C_IDLE, 1, 0, 3, 0);
        clear_in();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_waddr = 5'd9;
        id_rt_addr = 5'd9; id_uses_rt = 1'b1;
        step("lu_no_valid", C_IDLE, C_IDLE, 0, 0, 0, 0);
        id_valid = 1'b1;
        step("lu_rt", C_STALL, C_STALL, 0, 0, 0, 0);
        clear_in();
        redirect = 1'b1;
        step("redir_in_stall", C_FLUSH, C_FLUSH, 1, 0, 1, 0);
        clear_in();
        step("redir_after", C_IDLE, C_IDLE, 1, 1, 1, 1);

        hazard_rs();
        redirect = 1'b1;
        step("lu_and_redir", C_FLUSH, C_FLUSH, 1, 1, 1, 1);
        clear_in();
        step("lu_and_redir_after", C_IDLE, C_IDLE, 1, 2, 1, 2);

        hazard_rs();
        enable = 1'b0; redirect = 1'b1;
        ex_rs_addr = 5'd5; mem_waddr = 5'd5; mem_reg_write = 1'b1;
        step("en0_a", with_fwd(C_OFF, 2'b10, 2'b00), with_fwd(C_OFF, 2'b10, 2'b00), 1, 2, 1, 2);
        step("en0_b", with_fwd(C_OFF, 2'b10, 2'b00), with_fwd(C_OFF, 2'b10, 2'b00), 1, 2, 1, 2);

        clear_in();
        hazard_rs();
        step("stall_pre_freeze", C_STALL, C_STALL, 1, 2, 1, 2);
        clear_in();
        enable = 1'b0;
        step("stall_frozen", C_OFF, C_OFF, 2, 2, 2, 2);
        enable = 1'b1;
        step("stall_resume1", C_IDLE, C_STALL, 2, 2, 2, 2);
        step("stall_resume2", C_IDLE, C_STALL, 2, 2, 3, 2);

        hazard_rs();
        step("rst_stall_pre", C_STALL, C_STALL, 2, 2, 4, 2);
        clear_in();
        arst_n = 1'b0;
        step("rst_mid_stall", C_OFF, C_OFF, 3, 2, 5, 2);
        arst_n = 1'b1;
        step("rst_after", C_IDLE, C_IDLE, 0, 0, 0, 0);

        redirect = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step($sformatf("sat_%0d", k), C_FLUSH, C_FLUSH, 0, (k > 15) ? 4'd15 : 4'(k),
                 0, (k > 15) ? 4'd15 : 4'(k));
        end
        perf_clr = 1'b1;
        step("sat_clr", C_FLUSH, C_FLUSH, 0, 15, 0, 15);
        clear_in();
        step("after_clr", C_IDLE, C_IDLE, 0, 0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
